// File: rtl/traffic_timer.sv
// Timing and sensor front-end for the intersection light controller: seconds-rate prescaler,
// phase counters driven by light feedback, debounced/latched vehicle requests, conflict flag.
module traffic_timer #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned DEBOUNCE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       NS_SENSOR,
  input  logic       EW_SENSOR,
  input  logic       NS_GREEN,
  input  logic       NS_YELLOW,
  input  logic       EW_GREEN,
  input  logic       EW_YELLOW,
  output logic [4:0] nsCounter,
  output logic [3:0] ewCounter,
  output logic [1:0] yellowCounter,
  output logic       NS_VEHICLE_DETECT,
  output logic       EW_VEHICLE_DETECT,
  output logic       tick,
  output logic       conflict
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [PW-1:0] PresLast = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DebLast  = DW'(DEBOUNCE - 1);

  // Prescaler
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q;
  logic          wrap;

  assign wrap    = (presc_q == PresLast);
  assign presc_d = wrap ? '0 : presc_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= wrap;
    end
  end

  // Phase counters; counters advance on the wrap edge so the new value lines up with tick=1
  logic [4:0] ns_cnt_q, ns_cnt_d;
  logic [3:0] ew_cnt_q, ew_cnt_d;
  logic [1:0] yel_cnt_q, yel_cnt_d;
  logic       yel_on;

  assign yel_on = NS_YELLOW | EW_YELLOW;

  always_comb begin
    ns_cnt_d  = ns_cnt_q;
    ew_cnt_d  = ew_cnt_q;
    yel_cnt_d = yel_cnt_q;

    // NS wraps 31->0 on purpose so the controller re-evaluates the EW request
    if (!NS_GREEN) begin
      ns_cnt_d = '0;
    end else if (wrap) begin
      ns_cnt_d = ns_cnt_q + 5'd1;
    end

    if (!EW_GREEN) begin
      ew_cnt_d = '0;
    end else if (wrap && (ew_cnt_q != 4'd15)) begin
      ew_cnt_d = ew_cnt_q + 4'd1;
    end

    if (!yel_on) begin
      yel_cnt_d = '0;
    end else if (wrap && (yel_cnt_q != 2'd3)) begin
      yel_cnt_d = yel_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ns_cnt_q  <= '0;
      ew_cnt_q  <= '0;
      yel_cnt_q <= '0;
    end else begin
      ns_cnt_q  <= ns_cnt_d;
      ew_cnt_q  <= ew_cnt_d;
      yel_cnt_q <= yel_cnt_d;
    end
  end

  // Sensor path: index 0 is NS, index 1 is EW
  logic [1:0]         raw;
  logic [1:0]         served;
  logic [1:0]         sync1_q, sync2_q;
  logic [1:0]         level_q, level_d;
  logic [1:0][DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [1:0]         detect_q, detect_d;

  assign raw    = {EW_SENSOR, NS_SENSOR};
  assign served = {EW_GREEN, NS_GREEN};

  always_comb begin
    level_d   = level_q;
    deb_cnt_d = '0;
    detect_d  = detect_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != level_q[i]) begin
        if (deb_cnt_q[i] == DebLast) begin
          level_d[i] = ~level_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
      // Serving the phase wins over a simultaneous new request
      if (served[i]) begin
        detect_d[i] = 1'b0;
      end else if (level_q[i]) begin
        detect_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      deb_cnt_q <= '0;
      detect_q  <= '0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      deb_cnt_q <= deb_cnt_d;
      detect_q  <= detect_d;
    end
  end

  // Conflict flag
  logic conflict_q, conflict_d;

  assign conflict_d = conflict_q | (NS_GREEN & EW_GREEN) | (NS_YELLOW & EW_YELLOW) |
                      (NS_GREEN & NS_YELLOW) | (EW_GREEN & EW_YELLOW);

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_q <= 1'b0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign nsCounter         = ns_cnt_q;
  assign ewCounter         = ew_cnt_q;
  assign yellowCounter     = yel_cnt_q;
  assign NS_VEHICLE_DETECT = detect_q[0];
  assign EW_VEHICLE_DETECT = detect_q[1];
  assign tick              = tick_q;
  assign conflict          = conflict_q;

endmodule

// File: tb/tb_traffic_timer.sv
// Directed self-checking bench for traffic_timer with TICK_DIV=4, DEBOUNCE=3.
module tb_traffic_timer;

  logic       clk;
  logic       rst;
  logic       NS_SENSOR, EW_SENSOR;
  logic       NS_GREEN, NS_YELLOW, EW_GREEN, EW_YELLOW;
  logic [4:0] nsCounter;
  logic [3:0] ewCounter;
  logic [1:0] yellowCounter;
  logic       NS_VEHICLE_DETECT, EW_VEHICLE_DETECT;
  logic       tick;
  logic       conflict;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  traffic_timer #(
    .TICK_DIV(4),
    .DEBOUNCE(3)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .NS_SENSOR        (NS_SENSOR),
    .EW_SENSOR        (EW_SENSOR),
    .NS_GREEN         (NS_GREEN),
    .NS_YELLOW        (NS_YELLOW),
    .EW_GREEN         (EW_GREEN),
    .EW_YELLOW        (EW_YELLOW),
    .nsCounter        (nsCounter),
    .ewCounter        (ewCounter),
    .yellowCounter    (yellowCounter),
    .NS_VEHICLE_DETECT(NS_VEHICLE_DETECT),
    .EW_VEHICLE_DETECT(EW_VEHICLE_DETECT),
    .tick             (tick),
    .conflict         (conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Advance n rising edges; returns on the following falling edge
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ns"}, 32'(nsCounter), 0);
    check({tag, "_ew"}, 32'(ewCounter), 0);
    check({tag, "_yel"}, 32'(yellowCounter), 0);
    check({tag, "_nsdet"}, 32'(NS_VEHICLE_DETECT), 0);
    check({tag, "_ewdet"}, 32'(EW_VEHICLE_DETECT), 0);
    check({tag, "_tick"}, 32'(tick), 0);
    check({tag, "_conf"}, 32'(conflict), 0);
  endtask

  initial begin
    rst       = 1'b1;
    NS_SENSOR = 1'b0;
    EW_SENSOR = 1'b0;
    NS_GREEN  = 1'b0;
    NS_YELLOW = 1'b0;
    EW_GREEN  = 1'b0;
    EW_YELLOW = 1'b0;

    // Reset and prescaler
    @(negedge clk);
    step(3);
    check_all_zero("reset");
    rst = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      check("tick_period", 32'(tick), (i % 4 == 0) ? 1 : 0);
    end

    // NS wrap: cyc%4==0 here, so each 4 steps lands on a tick cycle
    NS_GREEN = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      step(4);
      check("ns_count", 32'(nsCounter), 32'(k % 32));
    end
    step(3);
    check("ns_hold", 32'(nsCounter), 1);
    NS_GREEN = 1'b0;  // falling edge coincides with a wrap edge
    step(1);
    check("ns_clear", 32'(nsCounter), 0);

    // EW saturate
    EW_GREEN = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step(4);
      check("ew_count", 32'(ewCounter), (k > 15) ? 15 : k);
    end
    EW_GREEN  = 1'b0;
    EW_YELLOW = 1'b1;
    step(1);
    check("ew_clear", 32'(ewCounter), 0);
    step(3);
    check("yel_count", 32'(yellowCounter), 1);
    for (int k = 2; k <= 6; k++) begin
      step(4);
      check("yel_count", 32'(yellowCounter), (k > 3) ? 3 : k);
    end
    EW_YELLOW = 1'b0;
    step(1);
    check("yel_clear", 32'(yellowCounter), 0);
    check("no_conflict", 32'(conflict), 0);

    // Debounce: short glitch rejected
    EW_SENSOR = 1'b1;
    step(2);
    EW_SENSOR = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      check("ew_glitch", 32'(EW_VEHICLE_DETECT), 0);
    end

    // Clean 10-cycle pulse: detect at cycle 6, latched afterwards
    EW_SENSOR = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      check("ew_det_rise", 32'(EW_VEHICLE_DETECT), (i >= 6) ? 1 : 0);
    end
    EW_SENSOR = 1'b0;
    step(10);
    check("ew_det_latched", 32'(EW_VEHICLE_DETECT), 1);
    EW_GREEN = 1'b1;
    step(1);
    check("ew_det_served", 32'(EW_VEHICLE_DETECT), 0);

    // Set/clear collision: green held while debounced level is high
    EW_SENSOR = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      check("ew_collision", 32'(EW_VEHICLE_DETECT), 0);
    end
    EW_GREEN = 1'b0;
    step(1);
    check("ew_det_after_green", 32'(EW_VEHICLE_DETECT), 1);
    EW_SENSOR = 1'b0;

    // NS request path
    NS_SENSOR = 1'b1;
    step(5);
    check("ns_det_early", 32'(NS_VEHICLE_DETECT), 0);
    step(1);
    check("ns_det_rise", 32'(NS_VEHICLE_DETECT), 1);
    NS_SENSOR = 1'b0;
    step(6);
    NS_GREEN = 1'b1;
    step(1);
    check("ns_det_served", 32'(NS_VEHICLE_DETECT), 0);
    NS_GREEN = 1'b0;
    step(2);
    check("ns_det_stays_clear", 32'(NS_VEHICLE_DETECT), 0);

    // Conflict: sticky until reset
    check("conf_before", 32'(conflict), 0);
    NS_GREEN = 1'b1;
    EW_GREEN = 1'b1;
    step(1);
    check("conf_set", 32'(conflict), 1);
    NS_GREEN = 1'b0;
    EW_GREEN = 1'b0;
    step(3);
    check("conf_sticky", 32'(conflict), 1);
    NS_YELLOW = 1'b1;
    EW_YELLOW = 1'b1;
    step(1);
    NS_YELLOW = 1'b0;
    EW_YELLOW = 1'b0;

    // Reset mid-run, then first tick TICK_DIV cycles after release
    rst = 1'b1;
    step(1);
    check_all_zero("rst2");
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step(1);
      check("tick_after_rst", 32'(tick), (i == 4) ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/traffic_timer.md
# traffic_timer

Timing and sensor front-end for the intersection light controller. It divides the system clock into a seconds-rate tick and generates the phase counters `nsCounter`, `ewCounter` and `yellowCounter` from the light outputs fed back from the controller. It also synchronises, debounces and latches the two vehicle sensors into `NS_VEHICLE_DETECT` / `EW_VEHICLE_DETECT`. It sits directly upstream of the controller, and its outputs connect one-to-one to the controller's inputs.

## Interface
- `TICK_DIV`, default 50_000_000: clock cycles per tick; legal range ≥ 2.
- `DEBOUNCE`, default 16: consecutive identical synchronised sensor samples required to change the debounced level; legal range ≥ 1.
- `clk` input 1: system clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `NS_SENSOR` input 1: raw asynchronous NS vehicle loop.
- `EW_SENSOR` input 1: raw asynchronous EW vehicle loop.
- `NS_GREEN`, `NS_YELLOW`, `EW_GREEN`, `EW_YELLOW` input 1 each: light-state feedback from the controller.
- `nsCounter` output 5: NS green phase time, in ticks.
- `ewCounter` output 4: EW green phase time, in ticks.
- `yellowCounter` output 2: yellow phase time, in ticks.
- `NS_VEHICLE_DETECT` output 1: latched NS service request.
- `EW_VEHICLE_DETECT` output 1: latched EW service request.
- `tick` output 1: one-cycle prescaler pulse, for debug and other timers.
- `conflict` output 1: sticky fault flag for illegal feedback combinations.

## Operation
- **Prescaler.** A `$clog2(TICK_DIV)`-bit counter counts 0 to TICK_DIV-1 and then wraps to 0. `tick` is registered: it is 1 for exactly the cycle after the prescaler reaches TICK_DIV-1, so the period is TICK_DIV cycles.
- **nsCounter.**
  - While NS_GREEN=1, it increments on each tick cycle and wraps 31→0.
  - The wrap is deliberate: a change of value every 32 ticks makes the controller re-evaluate `EW_VEHICLE_DETECT` at 31.
  - While NS_GREEN=0, it is cleared to 0 on the next clock.
- **ewCounter.**
  - While EW_GREEN=1, it increments on each tick and saturates at 15.
  - While EW_GREEN=0, it is cleared to 0.
- **yellowCounter.**
  - While (NS_YELLOW | EW_YELLOW)=1, it increments on each tick and saturates at 3.
  - Otherwise it is cleared to 0.
- **Counter priority** (per counter): rst > clear (phase light low) > increment (tick & phase light high) > hold.
- **Sensor path.**
  - Two-flop synchroniser per sensor.
  - Per-sensor debounce counter: it resets whenever the synchronised sample equals the debounced level. When it reaches DEBOUNCE-1 with a differing sample, the debounced level toggles and the counter resets.
- **Request latch.** `X_VEHICLE_DETECT` sets on the clock after the debounced X level is 1. It clears when X_GREEN=1, because the request has then been served. If set and clear are both true in the same cycle, clear wins.
- **Conflict detection.**
  - `conflict` sets if any of (NS_GREEN & EW_GREEN), (NS_YELLOW & EW_YELLOW), (NS_GREEN & NS_YELLOW) or (EW_GREEN & EW_YELLOW) is true on a clock edge.
  - It stays set until rst.
  - Counters keep operating per the rules above during a conflict; no masking is applied.

## Timing
- **Reset values:** all counters 0, prescaler 0, `tick`=0, both detects 0, debounced levels 0, synchroniser flops 0, `conflict`=0.
- **Counter latency:** the counter update is visible in the same cycle that `tick`=1. It is registered on the edge where the prescaler wraps.
- **Feedback-to-clear latency:** 1 clock. A light dropping in cycle n gives a cleared counter in cycle n+1, even if `tick`=1 in cycle n.
- **Sensor-to-detect latency:**
  - 2 cycles of synchroniser, then DEBOUNCE cycles of stable sample, then 1 cycle to the latch.
  - Total 3+DEBOUNCE cycles for a clean edge.
  - Glitches shorter than DEBOUNCE synchronised cycles are rejected.
- **Reset mid-phase:** all state returns to reset values on the next edge. The prescaler restarts, so the first tick after rst deasserts arrives TICK_DIV cycles later.
- **Simultaneous events:** a tick in the same cycle as a phase-light rising edge increments the counter from 0 to 1. A phase-light falling edge always takes the clear path.

## Test plan
All scenarios use TICK_DIV=4 and DEBOUNCE=3.
- **Reset/prescaler:** hold rst 3 cycles, then release → all outputs 0; `tick` pulses every 4 cycles, the first 4 cycles after release.
- **NS wrap:** NS_GREEN=1, others 0, for 33 ticks → `nsCounter` runs 0..31, reaches 0 at tick 32 and 1 at tick 33. Drop NS_GREEN → `nsCounter`=0 one clock later.
- **EW saturate and yellow saturate:**
  - EW_GREEN=1 for 20 ticks → `ewCounter` holds at 15.
  - EW_YELLOW=1 for 6 ticks → `yellowCounter` holds at 3; it clears 1 clock after EW_YELLOW=0.
- **Debounce/latch:**
  - EW_SENSOR pulse of 2 cycles → `EW_VEHICLE_DETECT` stays 0.
  - 10-cycle pulse → `EW_VEHICLE_DETECT`=1 at cycle 6 after the rising edge and stays 1 after the sensor falls.
  - Raising EW_GREEN clears it on the next clock.
- **Set/clear collision:** EW_GREEN=1 while the debounced EW sensor is high → `EW_VEHICLE_DETECT` stays 0.
- **Conflict:** NS_GREEN=EW_GREEN=1 for 1 cycle → `conflict`=1 on the next clock and it persists after the condition clears. rst → `conflict`=0.
